// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dlx_pkg
//  Description : Shared DLX definitions: opcode values, control-vector bit
//                indices and instruction field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package dlx_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_LOAD  = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd5;
  localparam logic [5:0] OP_STORE = 6'd6;
  localparam logic [5:0] OP_BNEZ  = 6'd9;
  localparam logic [5:0] OP_HALT  = 6'd10;
  localparam logic [5:0] OP_JAL   = 6'd11;
  localparam logic [5:0] OP_RET   = 6'd12;

  // Control vector bit positions: {Return,Jump,Branch,Store,Load,ALU1op,ALU2op}
  localparam int CTL_ALU2   = 0;
  localparam int CTL_ALU1   = 1;
  localparam int CTL_LOAD   = 2;
  localparam int CTL_STORE  = 3;
  localparam int CTL_BRANCH = 4;
  localparam int CTL_JUMP   = 5;
  localparam int CTL_RET    = 6;
  localparam int CTL_W      = 7;

  // Instruction field positions
  localparam int OPC_LSB  = 26;
  localparam int OPC_W    = 6;
  localparam int RS_LSB   = 21;
  localparam int RT_LSB   = 16;
  localparam int RD_LSB   = 11;
  localparam int IMM16_W  = 16;
  localparam int IMM20_W  = 20;

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : decode_scoreboard
//  Description : Load-use pending bits, one per architectural register.
//                Set and clear ports update the bits; two combinational busy
//                lookups see the same-cycle clear already applied.
//  Ports       : i_clk, i_rst_n          clock / async active-low reset
//                i_set_en, i_set_reg     mark register pending (reg 0 ignored)
//                i_clr_en, i_clr_reg     writeback clears pending bit
//                i_rd_a/b, o_busy_a/b    busy lookups
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_reg,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_reg,
  input  logic [REG_W-1:0] i_rd_a,
  input  logic [REG_W-1:0] i_rd_b,
  output logic             o_busy_a,
  output logic             o_busy_b
);

  logic [NUM_REGS-1:0] r_pend;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
      // Register 0 is never tracked; set takes priority over clear.
      logic w_set;
      logic w_clr;
      assign w_set = i_set_en && (i_set_reg == REG_W'(i)) && (i != 0);
      assign w_clr = i_clr_en && (i_clr_reg == REG_W'(i));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_pend[i] <= 1'b0;
        end else if (w_set) begin
          r_pend[i] <= 1'b1;
        end else if (w_clr) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  endgenerate

  // Bypass: a writeback in this cycle already frees the register.
  assign o_busy_a = r_pend[i_rd_a] && !(i_clr_en && (i_clr_reg == i_rd_a));
  assign o_busy_b = r_pend[i_rd_b] && !(i_clr_en && (i_clr_reg == i_rd_b));

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered, handshaked DLX decode stage with load-use
//                scoreboard and HALT latch.
//  Ports       : clk_pi, rst_n_pi                clock / async active-low reset
//                in_valid_pi/in_ready_po         fetch handshake
//                instr_pi, pc_pi                 instruction and its pc
//                flush_pi                        kill output reg + halt latch
//                wb_valid_pi, wb_reg_pi          load writeback
//                out_valid_po/out_ready_pi       execute handshake
//                opCode_po..pc_po                registered decode results
//                halted_po                       HALT accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import dlx_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DATA_W     = 32,
  parameter int JUMP_SHIFT = 2,
  localparam int REG_W     = $clog2(NUM_REGS)
) (
  input  logic              clk_pi,
  input  logic              rst_n_pi,
  input  logic              in_valid_pi,
  output logic              in_ready_po,
  input  logic [31:0]       instr_pi,
  input  logic [DATA_W-1:0] pc_pi,
  input  logic              flush_pi,
  input  logic              wb_valid_pi,
  input  logic [REG_W-1:0]  wb_reg_pi,
  output logic              out_valid_po,
  input  logic              out_ready_pi,
  output logic [5:0]        opCode_po,
  output logic [REG_W-1:0]  rs_po,
  output logic [REG_W-1:0]  rt_po,
  output logic [REG_W-1:0]  destReg_po,
  output logic [DATA_W-1:0] offset_po,
  output logic [CTL_W-1:0]  control_po,
  output logic              writeEnable_po,
  output logic              isHalt_po,
  output logic [DATA_W-1:0] pc_po,
  output logic              halted_po
);

  // ---------------- combinational decode ----------------
  logic [5:0]        w_op;
  logic [REG_W-1:0]  w_rs, w_rt, w_rd, w_dst;
  logic [DATA_W-1:0] w_imm16_ext, w_imm20_ext, w_off;
  logic [CTL_W-1:0]  w_ctl;
  logic              w_we, w_is_halt, w_use_rs, w_use_rt;

  assign w_op        = instr_pi[OPC_LSB +: OPC_W];
  assign w_rs        = instr_pi[RS_LSB +: REG_W];
  assign w_rt        = instr_pi[RT_LSB +: REG_W];
  assign w_rd        = instr_pi[RD_LSB +: REG_W];
  assign w_imm16_ext = {{(DATA_W-IMM16_W){instr_pi[IMM16_W-1]}}, instr_pi[IMM16_W-1:0]};
  assign w_imm20_ext = {{(DATA_W-IMM20_W){instr_pi[IMM20_W-1]}}, instr_pi[IMM20_W-1:0]};

  always_comb begin
    w_ctl     = '0;
    w_we      = 1'b0;
    w_is_halt = 1'b0;
    w_dst     = w_rt;
    w_off     = w_imm16_ext;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_ctl[CTL_ALU2] = 1'b1;
        w_we            = 1'b1;
        w_dst           = w_rd;
        w_use_rs        = 1'b1;
        w_use_rt        = 1'b1;
      end
      OP_LOAD: begin
        w_ctl[CTL_LOAD] = 1'b1;
        w_we            = 1'b1;
        w_use_rs        = 1'b1;
      end
      OP_ADDI: begin
        w_ctl[CTL_ALU1] = 1'b1;
        w_we            = 1'b1;
        w_use_rs        = 1'b1;
      end
      OP_STORE: begin
        w_ctl[CTL_STORE] = 1'b1;
        w_use_rs         = 1'b1;
        w_use_rt         = 1'b1;
      end
      OP_BNEZ: begin
        w_ctl[CTL_BRANCH] = 1'b1;
        w_use_rs          = 1'b1;
      end
      OP_HALT: begin
        w_is_halt = 1'b1;
      end
      OP_JAL: begin
        w_ctl[CTL_JUMP] = 1'b1;
        w_we            = 1'b1;
        w_dst           = w_rs;
        w_off           = w_imm20_ext << JUMP_SHIFT;
      end
      OP_RET: begin
        w_ctl[CTL_RET] = 1'b1;
        w_use_rs       = 1'b1;
      end
      default: ;  // NOP and unknown opcodes: no control, no write
    endcase
  end

  // ---------------- scoreboard & handshake ----------------
  logic r_out_valid, r_halted;
  logic w_busy_rs, w_busy_rt, w_hazard, w_accept, w_sb_set;

  assign w_hazard    = (w_use_rs && w_busy_rs) || (w_use_rt && w_busy_rt);
  assign in_ready_po = !r_halted && !w_hazard && (!r_out_valid || out_ready_pi);
  // A flush in the same cycle swallows the transfer entirely.
  assign w_accept    = in_valid_pi && in_ready_po && !flush_pi;
  assign w_sb_set    = w_accept && (w_op == OP_LOAD) && (w_dst != '0);

  decode_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_scoreboard (
    .i_clk     (clk_pi),
    .i_rst_n   (rst_n_pi),
    .i_set_en  (w_sb_set),
    .i_set_reg (w_dst),
    .i_clr_en  (wb_valid_pi),
    .i_clr_reg (wb_reg_pi),
    .i_rd_a    (w_rs),
    .i_rd_b    (w_rt),
    .o_busy_a  (w_busy_rs),
    .o_busy_b  (w_busy_rt)
  );

  // ---------------- output register ----------------
  logic [5:0]        r_op;
  logic [REG_W-1:0]  r_rs, r_rt, r_dst;
  logic [DATA_W-1:0] r_off, r_pc;
  logic [CTL_W-1:0]  r_ctl;
  logic              r_we, r_halt;

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_op        <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_dst       <= '0;
      r_off       <= '0;
      r_ctl       <= '0;
      r_we        <= 1'b0;
      r_halt      <= 1'b0;
      r_pc        <= '0;
    end else begin
      if (flush_pi) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
      end else if (out_ready_pi) begin
        r_out_valid <= 1'b0;
      end

      if (flush_pi) begin
        r_halted <= 1'b0;
      end else if (w_accept && w_is_halt) begin
        r_halted <= 1'b1;
      end

      if (w_accept) begin
        r_op   <= w_op;
        r_rs   <= w_rs;
        r_rt   <= w_rt;
        r_dst  <= w_dst;
        r_off  <= w_off;
        r_ctl  <= w_ctl;
        r_we   <= w_we;
        r_halt <= w_is_halt;
        r_pc   <= pc_pi;
      end
    end
  end

  assign out_valid_po   = r_out_valid;
  assign halted_po      = r_halted;
  assign opCode_po      = r_op;
  assign rs_po          = r_rs;
  assign rt_po          = r_rt;
  assign destReg_po     = r_dst;
  assign offset_po      = r_off;
  assign control_po     = r_ctl;
  assign writeEnable_po = r_we;
  assign isHalt_po      = r_halt;
  assign pc_po          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed vector table,
//                hand-written multi-cycle sequences and randomized traffic
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instr, pc;
  logic        flush, wb_valid;
  logic [4:0]  wb_reg;
  logic        out_valid, out_ready;
  logic [5:0]  opCode;
  logic [4:0]  rs_o, rt_o, destReg;
  logic [31:0] offset, pc_o;
  logic [6:0]  control;
  logic        writeEnable, isHalt, halted;

  always #5 clk = ~clk;

  decode_stage #(.NUM_REGS(32), .DATA_W(32), .JUMP_SHIFT(2)) dut (
    .clk_pi        (clk),
    .rst_n_pi      (rst_n),
    .in_valid_pi   (in_valid),
    .in_ready_po   (in_ready),
    .instr_pi      (instr),
    .pc_pi         (pc),
    .flush_pi      (flush),
    .wb_valid_pi   (wb_valid),
    .wb_reg_pi     (wb_reg),
    .out_valid_po  (out_valid),
    .out_ready_pi  (out_ready),
    .opCode_po     (opCode),
    .rs_po         (rs_o),
    .rt_po         (rt_o),
    .destReg_po    (destReg),
    .offset_po     (offset),
    .control_po    (control),
    .writeEnable_po(writeEnable),
    .isHalt_po     (isHalt),
    .pc_po         (pc_o),
    .halted_po     (halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, dst;
    logic [31:0] off;
    logic [6:0]  ctl;
    logic        we, halt, use_rs, use_rt;
  } dec_t;

  dec_t        m_out;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic        m_valid, m_halted;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d        = '0;
    d.op     = ins[31:26];
    d.rs     = ins[25:21];
    d.rt     = ins[20:16];
    d.dst    = d.rt;
    d.off    = 32'($signed(ins[15:0]));
    case (d.op)
      6'd1:  begin d.ctl = 7'b0000001; d.we = 1; d.dst = ins[15:11]; d.use_rs = 1; d.use_rt = 1; end
      6'd4:  begin d.ctl = 7'b0000100; d.we = 1; d.use_rs = 1; end
      6'd5:  begin d.ctl = 7'b0000010; d.we = 1; d.use_rs = 1; end
      6'd6:  begin d.ctl = 7'b0001000; d.use_rs = 1; d.use_rt = 1; end
      6'd9:  begin d.ctl = 7'b0010000; d.use_rs = 1; end
      6'd10: begin d.halt = 1; end
      6'd11: begin d.ctl = 7'b0100000; d.we = 1; d.dst = d.rs;
                   d.off = 32'($signed(ins[19:0])) * 4; end
      6'd12: begin d.ctl = 7'b1000000; d.use_rs = 1; end
      default: ;
    endcase
    return d;
  endfunction

  task automatic model_reset();
    m_out = '0; m_pc = '0; m_pend = '0; m_valid = 0; m_halted = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":out_valid"}, out_valid, m_valid);
    chk({tag, ":halted"},    halted,    m_halted);
    chk({tag, ":opCode"},    opCode,    m_out.op);
    chk({tag, ":rs"},        rs_o,      m_out.rs);
    chk({tag, ":rt"},        rt_o,      m_out.rt);
    chk({tag, ":destReg"},   destReg,   m_out.dst);
    chk({tag, ":offset"},    offset,    m_out.off);
    chk({tag, ":control"},   control,   m_out.ctl);
    chk({tag, ":we"},        writeEnable, m_out.we);
    chk({tag, ":isHalt"},    isHalt,    m_out.halt);
    chk({tag, ":pc"},        pc_o,      m_pc);
  endtask

  // One clock cycle: drive at negedge, check ready, advance model at posedge,
  // check registered outputs shortly after.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input logic fl, input logic wbv,
                       input logic [4:0] wbr, output logic rdy);
    dec_t d;
    logic hz, exp_rdy, acc;
    @(negedge clk);
    in_valid = v; instr = ins; pc = p; out_ready = ordy;
    flush = fl; wb_valid = wbv; wb_reg = wbr;
    #1;
    d  = decode(ins);
    hz = (d.use_rs && m_pend[d.rs] && !(wbv && wbr == d.rs)) ||
         (d.use_rt && m_pend[d.rt] && !(wbv && wbr == d.rt));
    exp_rdy = !m_halted && !hz && (!m_valid || ordy);
    chk("in_ready", in_ready, exp_rdy);
    rdy = in_ready;
    acc = v && exp_rdy && !fl;
    @(posedge clk);
    if (wbv) m_pend[wbr] = 1'b0;
    if (acc && d.op == 6'd4 && d.dst != 0) m_pend[d.dst] = 1'b1;
    if (fl) m_valid = 0; else if (acc) m_valid = 1; else if (ordy) m_valid = 0;
    if (fl) m_halted = 0; else if (acc && d.halt) m_halted = 1;
    if (acc) begin m_out = d; m_pc = p; end
    #1;
    check_outputs("cyc");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [31:0] ins;
    logic [6:0]  ctl;
    logic [4:0]  dst;
    logic [31:0] off;
    logic        we;
  } vec_t;

  vec_t vecs [9];

  localparam logic [31:0] I_LOAD_R3 = 32'h1003_0000;
  localparam logic [31:0] I_ADD_435 = 32'h0465_2000;
  localparam logic [31:0] I_ADDI    = 32'h1422_FFFC;
  localparam logic [31:0] I_HALT    = 32'h2800_0000;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic r;
    vecs[0] = '{32'h0000_0000, 7'b0000000, 5'd0,  32'h0000_0000, 1'b0}; // NOP
    vecs[1] = '{32'h1422_FFFC, 7'b0000010, 5'd2,  32'hFFFF_FFFC, 1'b1}; // ADDI r2,r1,#-4
    vecs[2] = '{32'h2FE8_0001, 7'b0100000, 5'd31, 32'hFFE0_0004, 1'b1}; // JAL rs=31
    vecs[3] = '{32'hFC00_0000, 7'b0000000, 5'd0,  32'h0000_0000, 1'b0}; // opcode 63
    vecs[4] = '{32'h0465_2000, 7'b0000001, 5'd4,  32'h0000_2000, 1'b1}; // ADD r4,r3,r5
    vecs[5] = '{32'h1822_8000, 7'b0001000, 5'd2,  32'hFFFF_8000, 1'b0}; // STORE
    vecs[6] = '{32'h24E0_0010, 7'b0010000, 5'd0,  32'h0000_0010, 1'b0}; // BNEZ r7
    vecs[7] = '{32'h33E0_0000, 7'b1000000, 5'd0,  32'h0000_0000, 1'b0}; // RET r31
    vecs[8] = '{32'h1020_0004, 7'b0000100, 5'd0,  32'h0000_0004, 1'b1}; // LOAD r0 (no scoreboard)

    rst_n = 0; in_valid = 0; instr = 0; pc = 0; out_ready = 1;
    flush = 0; wb_valid = 0; wb_reg = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    // Table: back-to-back accepts with downstream ready
    for (int i = 0; i < 9; i++) begin
      cycle(1, vecs[i].ins, 32'h1000 + 32'(i) * 4, 1, 0, 0, 0, r);
      chk("tbl_accept", r, 1'b1);
      chk("tbl_valid",  out_valid, 1'b1);
      chk("tbl_ctl",    control, vecs[i].ctl);
      chk("tbl_dst",    destReg, vecs[i].dst);
      chk("tbl_off",    offset,  vecs[i].off);
      chk("tbl_we",     writeEnable, vecs[i].we);
    end

    // Load-use stall released by same-cycle writeback
    cycle(1, I_LOAD_R3, 32'h2000, 1, 0, 0, 0, r);
    chk("lu_load_acc", r, 1'b1);
    cycle(1, I_ADD_435, 32'h2004, 1, 0, 0, 0, r);
    chk("lu_stall0", r, 1'b0);
    cycle(1, I_ADD_435, 32'h2004, 1, 0, 0, 0, r);
    chk("lu_stall1", r, 1'b0);
    cycle(1, I_ADD_435, 32'h2004, 1, 0, 1, 5'd3, r);
    chk("lu_wb_accept", r, 1'b1);
    chk("lu_dst", destReg, 5'd4);
    chk("lu_pc",  pc_o, 32'h2004);

    // Backpressure: three cycles of out_ready low
    cycle(1, I_ADDI, 32'h3000, 1, 0, 0, 0, r);
    for (int i = 0; i < 3; i++) begin
      cycle(1, I_ADD_435, 32'h3004, 0, 0, 0, 0, r);
      chk("bp_ready_low", r, 1'b0);
      chk("bp_hold_pc",   pc_o, 32'h3000);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    cycle(1, I_ADD_435, 32'h3004, 1, 0, 0, 0, r);
    chk("bp_resume", r, 1'b1);
    chk("bp_new_pc", pc_o, 32'h3004);

    // HALT then flush
    cycle(1, I_HALT, 32'h4000, 1, 0, 0, 0, r);
    chk("halt_acc", halted, 1'b1);
    chk("halt_isHalt", isHalt, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1, I_ADDI, 32'h4004, 1, 0, 0, 0, r);
      chk("halt_blocks", r, 1'b0);
    end
    cycle(1, I_ADDI, 32'h4004, 1, 1, 0, 0, r);
    chk("flush_halted", halted, 1'b0);
    chk("flush_valid",  out_valid, 1'b0);
    cycle(1, I_ADDI, 32'h4008, 1, 0, 0, 0, r);
    chk("post_flush_acc", r, 1'b1);
    chk("post_flush_pc", pc_o, 32'h4008);

    // Asynchronous reset in the middle of a load-use stall
    cycle(1, I_LOAD_R3, 32'h5000, 1, 0, 0, 0, r);
    cycle(1, I_ADD_435, 32'h5004, 1, 0, 0, 0, r);
    chk("rst_stall", r, 1'b0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1;
    cycle(1, I_ADD_435, 32'h5008, 1, 0, 0, 0, r);
    chk("rst_sb_cleared", r, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins;
      logic [5:0]  op;
      int          sel;
      sel = $urandom_range(0, 19);
      case (sel)
        0, 1:    op = 6'd1;
        2, 3, 4: op = 6'd4;
        5, 6:    op = 6'd5;
        7:       op = 6'd6;
        8:       op = 6'd9;
        9:       op = ($urandom_range(0, 3) == 0) ? 6'd10 : 6'd0;
        10:      op = 6'd11;
        11:      op = 6'd12;
        12:      op = 6'($urandom);
        default: op = 6'd0;
      endcase
      ins = $urandom;
      ins[31:26] = op;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, ins, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
